fir_coef_loader: RTL

- Writer side of the FIR coefficient shift chain: holds a 21-entry coefficient table and serially shifts it into the filter.
- Drives the filter's coefficient data input and coefficient shift clock (`coef_in` / `clk_coef`).
- After loading, reads taps 0..15 back through the filter's `sw` / `coef_current` readback port and flags any mismatch.
- Sits between the host/control logic and the filter; runs on the system clock only.

---
 rtl/fir_coef_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Purpose: holds the FIR coefficient table, shifts it serially into the filter, then reads taps 0..15 back and flags mismatches.
// Latency: start to done is NTAPS*2*DIV + 3*16 clk cycles (216 with default parameters).
// Backpressure: none; start and table writes are ignored while busy, and the filter side is strictly clock-timed.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  coefficient table write port (ignored while busy or for wr_addr >= NTAPS)
//   start                  single-cycle load-and-verify request
//   coef_out, clk_coef     serial coefficient word and generated shift clock towards the filter
//   sw, coef_current       readback tap select and readback value from the filter
//   busy, done, error      sequence status; error is sticky until the next accepted start
//   fail_idx               index of the first mismatching tap, valid when error=1
module fir_coef_loader #(
    parameter int NTAPS  = 21,
    parameter int COEF_W = 16,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              start,
    output logic [COEF_W-1:0] coef_out,
    output logic              clk_coef,
    output logic [3:0]        sw,
    input  logic [COEF_W-1:0] coef_current,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        fail_idx
);

    localparam int TW = $clog2(NTAPS);
    localparam int PW = (DIV > 1) ? $clog2(2 * DIV) : 1;
    // Only taps 0..15 are reachable through the 4-bit readback select.
    localparam int NV = (NTAPS < 16) ? NTAPS : 16;
    localparam logic [5:0] NTAPS6 = 6'(NTAPS);

    typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;

    state_t            state, state_nx;
    logic [TW-1:0]     tap, tap_nx;
    logic [PW-1:0]     ph, ph_nx;
    logic [1:0]        sub, sub_nx;
    logic [3:0]        idx, idx_nx;
    logic [COEF_W-1:0] coef_nx;
    logic              clk_coef_nx;
    logic [3:0]        sw_nx;
    logic              done_nx, error_nx;
    logic [3:0]        fail_nx;
    logic              load;
    logic              wr_ok;
    logic [COEF_W-1:0] load_word;

    logic [COEF_W-1:0] tbl [NTAPS];

    assign busy  = (state == SHIFT) || (state == VERIFY);
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < NTAPS6);

    // Table is deliberately not reset: software-loaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tbl[TW'(wr_addr)] <= wr_data;
        end
    end

    // A write landing in the same cycle as start has not reached the table yet,
    // so forward it into the first word sent.
    assign load_word = (wr_ok && (wr_addr == 5'(tap_nx))) ? wr_data : tbl[tap_nx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tap      <= '0;
            ph       <= '0;
            sub      <= '0;
            idx      <= '0;
            coef_out <= '0;
            clk_coef <= 1'b0;
            sw       <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            fail_idx <= '0;
        end else begin
            state    <= state_nx;
            tap      <= tap_nx;
            ph       <= ph_nx;
            sub      <= sub_nx;
            idx      <= idx_nx;
            coef_out <= coef_nx;
            clk_coef <= clk_coef_nx;
            sw       <= sw_nx;
            done     <= done_nx;
            error    <= error_nx;
            fail_idx <= fail_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tap_nx      = tap;
        ph_nx       = ph;
        sub_nx      = sub;
        idx_nx      = idx;
        coef_nx     = coef_out;
        clk_coef_nx = 1'b0;
        sw_nx       = sw;
        done_nx     = done;
        error_nx    = error;
        fail_nx     = fail_idx;
        load        = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = SHIFT;
                    tap_nx   = TW'(NTAPS - 1);
                    ph_nx    = '0;
                    done_nx  = 1'b0;
                    error_nx = 1'b0;
                    fail_nx  = '0;
                    load     = 1'b1;
                end
            end
            SHIFT: begin
                if (ph == PW'(2 * DIV - 1)) begin
                    ph_nx = '0;
                    if (tap == '0) begin
                        state_nx = VERIFY;
                        idx_nx   = '0;
                        sub_nx   = '0;
                        sw_nx    = '0;
                    end else begin
                        tap_nx = tap - TW'(1);
                        load   = 1'b1;
                    end
                end else begin
                    // Low for the first DIV cycles of a tap, high for the last DIV.
                    ph_nx       = ph + PW'(1);
                    clk_coef_nx = (ph_nx >= PW'(DIV));
                end
            end
            VERIFY: begin
                if (sub == 2'd2) begin
                    if ((coef_current != tbl[TW'(idx)]) && !error) begin
                        error_nx = 1'b1;
                        fail_nx  = idx;
                    end
                    sub_nx = '0;
                    if (idx == 4'(NV - 1)) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        sw_nx    = '0;
                    end else begin
                        idx_nx = idx + 4'd1;
                        sw_nx  = idx + 4'd1;
                    end
                end else begin
                    sub_nx = sub + 2'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (load) begin
            coef_nx = load_word;
        end
    end

endmodule
